// File: rtl/rr_sel_arbiter4_pkg.sv
// Shared definitions for the 4-channel round-robin select arbiter:
// state encodings, channel/select widths and a one-hot helper.
package rr_sel_arbiter4_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    typedef enum logic {
        StIdle  = ST_IDLE,
        StGrant = ST_GRANT
    } arb_state_e;

    // Decode a select value into the matching one-hot grant vector.
    function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_sel_arbiter4_pick4.sv
// rr_pick4: combinational round-robin picker. Scans req starting at last+1
// and wrapping mod 4, so the channel in 'last' ranks lowest.
module rr_pick4
    import rr_sel_arbiter4_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  logic [SEL_W-1:0]  last_i,
    output logic [SEL_W-1:0]  pick_o,
    output logic              pick_vld_o
);

    // First set request after 'last', wrapping; offset 4 wraps back onto 'last' itself.
    always_comb begin
        logic [SEL_W-1:0] idx;
        pick_o     = '0;
        pick_vld_o = 1'b0;
        idx        = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = last_i + SEL_W'(i);
            if (!pick_vld_o && req_i[idx]) begin
                pick_o     = idx;
                pick_vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_sel_arbiter4.sv
// rr_sel_arbiter4: 4-channel round-robin arbiter producing a registered
// 2-bit mux select that stays frozen for the whole grant.
// Optional build macro ARB_TIMEOUT_EN: forces rotation after HOLD_MAX cycles.
module rr_sel_arbiter4
    import rr_sel_arbiter4_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] req_i,
    input  logic              release_i,
    output logic [SEL_W-1:0]  sel_o,
    output logic [NUM_CH-1:0] grant_o,
    output logic              grant_valid_o
);

    // Counter must be able to hold HOLD_MAX without wrapping.
    if ((2 ** CNT_W) <= HOLD_MAX || HOLD_MAX == 0) begin : g_bad_cfg
        $error("rr_sel_arbiter4: CNT_W too narrow for HOLD_MAX");
    end

    arb_state_e        state_q;
    logic [SEL_W-1:0]  sel_q;
    logic [NUM_CH-1:0] grant_q;
    logic              grant_valid_q;
    logic [SEL_W-1:0]  last_q;

    logic [SEL_W-1:0]  pick_last;
    logic [SEL_W-1:0]  pick;
    logic              pick_vld;
    logic              rel_evt;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0]  hold_cnt_q;
    logic              timeout;

    // Timeout fires on the last cycle of a HOLD_MAX-long grant.
    always_comb begin
        timeout = (hold_cnt_q == CNT_W'(HOLD_MAX - 1));
    end
`endif

    // Release causes are OR-ed so simultaneous causes produce a single rotation.
    always_comb begin
        rel_evt = release_i | ~req_i[sel_q];
`ifdef ARB_TIMEOUT_EN
        rel_evt = rel_evt | timeout;
`endif
        // During a grant the current channel becomes 'last' for the re-pick.
        pick_last = (state_q == StGrant) ? sel_q : last_q;
    end

    rr_pick4 u_pick (
        .req_i      (req_i),
        .last_i     (pick_last),
        .pick_o     (pick),
        .pick_vld_o (pick_vld)
    );

    // Arbitration FSM with registered select/grant outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            sel_q         <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            last_q        <= '1;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q    <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_vld) begin
                        sel_q         <= pick;
                        grant_q       <= sel_onehot(pick);
                        grant_valid_q <= 1'b1;
                        state_q       <= StGrant;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt_q    <= '0;
`endif
                    end
                end
                StGrant: begin
                    if (rel_evt) begin
                        last_q <= sel_q;
                        if (pick_vld) begin
                            sel_q   <= pick;
                            grant_q <= sel_onehot(pick);
`ifdef ARB_TIMEOUT_EN
                            hold_cnt_q <= '0;
`endif
                        end else begin
                            // sel holds its last value so the mux input stays put.
                            grant_q       <= '0;
                            grant_valid_q <= 1'b0;
                            state_q       <= StIdle;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (hold_cnt_q != CNT_W'(HOLD_MAX)) begin
                        hold_cnt_q <= hold_cnt_q + CNT_W'(1);
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign sel_o         = sel_q;
    assign grant_o       = grant_q;
    assign grant_valid_o = grant_valid_q;

endmodule
